// File: rtl/move_uart_tx.sv
// rtl/move_uart_tx.sv - UART transmitter for outgoing moves, 8N1 (8E1 with MOVE_TX_PARITY_EN)
// A one-deep pending buffer holds a move that arrives while a frame is on the wire.
module move_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int CNT_W        = 16
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic       tx_ready,
   input  logic [7:0] move,
   output logic       tx_out,
   output logic       busy,
   output logic       tx_done,
   output logic       overrun
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef MOVE_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       pend_q, pend_d;
   logic             pend_valid_q, pend_valid_d;
   logic             overrun_q, overrun_d;
   logic             tx_out_q, tx_out_d;
   logic             busy_q, busy_d;
   logic             tx_done_q, tx_done_d;
`ifdef MOVE_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   logic             bit_last;
   logic             load_en;
   logic [7:0]       load_val;
   logic             direct_take;

   assign bit_last = (cnt_q == CNT_MAX);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         tx_out_q     <= 1'b1;
         busy_q       <= 1'b0;
         tx_done_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         overrun_q    <= overrun_d;
         tx_out_q     <= tx_out_d;
         busy_q       <= busy_d;
         tx_done_q    <= tx_done_d;
      end
   end

`ifdef MOVE_TX_PARITY_EN
   always_ff @(posedge clk_in) begin
      if (reset) par_q <= 1'b0;
      else       par_q <= par_d;
   end
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = (state_q == S_IDLE || bit_last) ? '0 : cnt_q + CNT_W'(1);
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      overrun_d    = overrun_q;
      load_en      = 1'b0;
      load_val     = move;
`ifdef MOVE_TX_PARITY_EN
      par_d        = par_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (tx_ready) begin
               load_en = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_last) state_d = S_DATA;
         end
         S_DATA: begin
            if (bit_last) begin
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef MOVE_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef MOVE_TX_PARITY_EN
         S_PARITY: begin
            if (bit_last) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (bit_last) begin
               if (pend_valid_q) begin
                  load_en      = 1'b1;
                  load_val     = pend_q;
                  pend_valid_d = 1'b0;
                  state_d      = S_START;
               end else if (tx_ready) begin
                  load_en = 1'b1;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A strobe not consumed directly goes to the pending slot, or is dropped if it is full
      direct_take = (state_q == S_IDLE) || (state_q == S_STOP && bit_last && !pend_valid_q);
      if (tx_ready && !direct_take) begin
         if (!pend_valid_q) begin
            pend_d       = move;
            pend_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end

      if (load_en) begin
         shift_d = load_val;
`ifdef MOVE_TX_PARITY_EN
         par_d   = ^load_val;
`endif
      end
   end

   // Outputs are registered from next-state values so they line up with the state register
   always_comb begin
      tx_out_d = 1'b1;
      case (state_d)
         S_START:  tx_out_d = 1'b0;
         S_DATA:   tx_out_d = shift_d[bit_idx_d];
`ifdef MOVE_TX_PARITY_EN
         S_PARITY: tx_out_d = par_d;
`endif
         default:  tx_out_d = 1'b1;
      endcase
      busy_d    = (state_d != S_IDLE) || pend_valid_d;
      tx_done_d = (state_d == S_STOP) && (cnt_d == CNT_MAX);
   end

   assign tx_out  = tx_out_q;
   assign busy    = busy_q;
   assign tx_done = tx_done_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_move_uart_tx.sv
// tb/tb_move_uart_tx.sv - randomized bench for move_uart_tx against a slot-timeline model
// Honours MOVE_TX_PARITY_EN for the expected frame shape.
module tb_move_uart_tx;

   localparam int CPB = 4;
`ifdef MOVE_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FL   = NB * CPB;
   localparam int MAXC = 16384;

   logic       clk_in   = 1'b0;
   logic       reset    = 1'b1;
   logic       tx_ready = 1'b0;
   logic [7:0] move     = 8'h00;
   logic       tx_out, busy, tx_done, overrun;

   move_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
      .clk_in   (clk_in),
      .reset    (reset),
      .tx_ready (tx_ready),
      .move     (move),
      .tx_out   (tx_out),
      .busy     (busy),
      .tx_done  (tx_done),
      .overrun  (overrun)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   // Expected outputs per slot; slot n is the cycle following clock edge n
   bit exp_tx   [MAXC];
   bit exp_busy [MAXC];
   bit exp_done [MAXC];
   bit exp_ovr  [MAXC];
   int last_start = -1000;
   int last_end   = -1000;
   int n_chk  = 0;
   int n_pass = 0;
   bit checking = 1'b1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at slot %0d: got %0h, expected %0h", tag, cyc, got, exp);
   endtask

   function automatic bit frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
`ifdef MOVE_TX_PARITY_EN
      if (i == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic schedule(input logic [7:0] b, input int s);
      for (int t = 0; t < FL; t++) begin
         if (s + t < MAXC) begin
            exp_tx[s+t]   = frame_bit(b, t / CPB);
            exp_busy[s+t] = 1'b1;
            exp_done[s+t] = (t == FL - 1);
         end
      end
      last_start = s;
      last_end   = s + FL - 1;
   endtask

   // Strobe sampled at edge cyc+1; the DUT state in slot cyc decides its fate
   task automatic model_strobe(input logic [7:0] b);
      int p = cyc;
      int e = cyc + 1;
      if (last_end <= p)        schedule(b, e);
      else if (last_start <= p) schedule(b, last_end + 1);
      else for (int t = e; t < MAXC; t++) exp_ovr[t] = 1'b1;
   endtask

   task automatic model_reset();
      for (int t = cyc + 1; t < MAXC; t++) begin
         exp_tx[t]   = 1'b1;
         exp_busy[t] = 1'b0;
         exp_done[t] = 1'b0;
         exp_ovr[t]  = 1'b0;
      end
      last_start = -1000;
      last_end   = -1000;
   endtask

   always @(negedge clk_in) begin
      if (checking && cyc >= 1 && cyc < MAXC) begin
         check_eq("tx_out",  32'(tx_out),  32'(exp_tx[cyc]));
         check_eq("busy",    32'(busy),    32'(exp_busy[cyc]));
         check_eq("tx_done", 32'(tx_done), 32'(exp_done[cyc]));
         check_eq("overrun", 32'(overrun), 32'(exp_ovr[cyc]));
      end
   end

   task automatic strobe(input logic [7:0] b);
      tx_ready = 1'b1;
      move     = b;
      model_strobe(b);
      @(posedge clk_in); #1;
      tx_ready = 1'b0;
      move     = 8'($urandom);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      model_reset();
      @(posedge clk_in); #1;
      reset = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk_in); #1;
         move = 8'($urandom);
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t && cyc < MAXC) begin
         @(posedge clk_in); #1;
      end
   endtask

   logic [8:0] bits;
   int         s;

   initial begin
      for (int t = 0; t < MAXC; t++) exp_tx[t] = 1'b1;
      repeat (3) @(posedge clk_in);
      #1 reset = 1'b0;

      // Basic frame; start bit plus data of 8'h35 sampled mid-bit
      strobe(8'h35);
      s = last_start;
      for (int i = 0; i < 9; i++) begin
         wait_until(s + i * CPB + 2);
         bits[i] = tx_out;
      end
      check_eq("frame35_bits", 32'(bits), 32'(9'b001101010));
      wait_until(last_end + 3);
      check_eq("idle_after35", 32'({busy, tx_out}), 32'(2'b01));

      // Queued move during DATA
      strobe(8'h35);
      wait_cyc(15);
      strobe(8'h42);
      wait_until(last_end + 3);

      // Overrun: third move dropped, flag sticky
      strobe(8'h35);
      wait_cyc(10);
      strobe(8'h11);
      wait_cyc(5);
      strobe(8'h22);
      wait_until(last_end + 3);
      check_eq("overrun_sticky", 32'(overrun), 32'd1);

      // Strobe in the tx_done cycle chains with no idle gap
      strobe(8'h5C);
      wait_until(last_end);
      strobe(8'hA0);
      wait_until(last_end + 3);

      // Reset during data bit 3, then a fresh frame
      strobe(8'h35);
      s = last_start;
      wait_until(s + CPB * 4 + 1);
      pulse_reset();
      check_eq("rst_state", 32'({tx_out, busy, overrun}), 32'(3'b100));
      wait_cyc(3);
      strobe(8'h35);
      wait_until(last_end + 3);

      for (int k = 0; k < 250 && cyc < MAXC - 600; k++) begin
         int r = $urandom_range(0, 39);
         if (r < 6 && last_end >= cyc) begin
            wait_until(last_end);
            strobe(8'($urandom));
         end else if (r == 6) begin
            wait_cyc($urandom_range(0, 30));
            pulse_reset();
         end else begin
            wait_cyc($urandom_range(0, 60));
            strobe(8'($urandom));
         end
      end
      wait_until(last_end + 3);

      checking = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/move_uart_tx.md
Name: move_uart_tx

Overview:
Serial transmitter for local moves going to the opponent board. The game FSM raises a one-cycle tx_ready alongside an 8-bit move code. This block latches the move and sends it as a UART frame: 8N1, or 8E1 when the optional feature is enabled. A one-deep pending buffer absorbs a second move that arrives while a frame is still on the wire.

Parameters:
CLKS_PER_BIT, 868, clk_in cycles per serial bit (100 MHz / 115200); legal range >= 2.
CNT_W, 16, width of the baud counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
clk_in  input  1  system clock
reset  input  1  synchronous, active-high
tx_ready  input  1  one-cycle strobe: move is valid and must be sent
move  input  8  move code; sampled only in the cycle tx_ready=1
tx_out  output  1  serial line; idles high
busy  output  1  high while a frame is in flight or a move is pending
tx_done  output  1  one-cycle pulse in the last cycle of each stop bit
overrun  output  1  sticky flag: a move was dropped; cleared only by reset

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk_in.
- Reset values: tx_out=1, busy=0, tx_done=0, overrun=0. State=IDLE, baud counter=0, bit index=0, pending buffer empty.
- Reset asserted mid-frame: tx_out returns to 1 on the next edge and the frame is abandoned. No tx_done is issued and the pending move is discarded.
- States:
  - IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE, or STOP -> START directly.
  - tx_out is registered and always driven from the current state and shift register.
- Baud timing: the counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state. Each serial bit holds for exactly CLKS_PER_BIT cycles, and a state advances when counter==CLKS_PER_BIT-1.
- Start of a frame:
  - In IDLE, tx_ready=1 at edge k latches move into the shift register and enters START.
  - tx_out=0 from edge k (visible in cycle k+1), so latency is one cycle.
- DATA: 8 bits, LSB first. The bit index wraps from 7 to 0 when leaving DATA.
- STOP: tx_out=1 for CLKS_PER_BIT cycles. tx_done=1 during the final cycle of the stop bit (counter==CLKS_PER_BIT-1).
- Leaving STOP:
  - If the pending buffer is valid, load it into the shift register, clear the buffer and enter START with no idle gap.
  - Otherwise, if tx_ready=1 in that same final cycle, load move directly and enter START.
  - Otherwise go to IDLE.
- tx_ready while not IDLE (covering START, DATA, PARITY, and STOP other than the case above):
  - Pending buffer empty: store move, pending_valid=1.
  - Pending buffer full: drop the new move and set overrun=1. The stored move is kept.
- busy = (state != IDLE) | pending_valid, registered so it rises the cycle after the accepting tx_ready. busy is 0 in the cycle after the final tx_done when nothing is queued.
- Frame length: 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity. Back-to-back frames are contiguous.
- The move code is opaque to this block; no validation is done.

Optional Feature:
Macro: MOVE_TX_PARITY_EN.
- Defined: the PARITY state is inserted between DATA and STOP. It sends the even-parity bit (XOR of the 8 data bits, computed at latch time) for CLKS_PER_BIT cycles, giving an 8E1 frame.
- Undefined: the PARITY state and its logic are absent; the frame is 8N1.
- All other timing is identical in both cases.

Test Plan:
- Basic frame (CLKS_PER_BIT=4): reset, then tx_ready pulse with move=8'h35.
  - tx_out bits, 4 cycles each: 0,1,0,1,0,1,1,0,0,1.
  - tx_done pulses once, 40 cycles after the frame starts; busy falls the next cycle; tx_out stays 1.
- Parity (MOVE_TX_PARITY_EN, CLKS_PER_BIT=4): move=8'h35 -> a parity bit of 0 follows the data bits; move=8'h07 -> parity bit 1. Each frame is 44 cycles.
- Queued move: send 8'h35, then tx_ready with 8'h42 during DATA.
  - The second frame's start bit begins in the cycle after tx_done.
  - Data for 8'h42 is 0,1,0,0,0,0,1,0. overrun stays 0.
- Overrun: while sending 8'h35, pulse tx_ready with 8'h11 then 8'h22.
  - Frames 8'h35 then 8'h11 are sent; 8'h22 is never sent.
  - overrun=1 and stays 1 until reset.
- Strobe on the last stop cycle: tx_ready with 8'hA0 in the tx_done cycle, buffer empty -> the next frame starts immediately, no IDLE cycle, and carries 8'hA0.
- Reset mid-frame: assert reset during DATA bit 3 -> next cycle tx_out=1, busy=0, overrun=0, no tx_done. A fresh tx_ready afterward sends a correct frame.
